motor_pwm_drive: RTL and testbench

MOTOR_PWM_DRIVE -- requirements
Module: motor_pwm_drive

---
 rtl/motor_pwm_drive.sv | 168 ++++++++++++++++
 tb/tb_motor_pwm_drive.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/motor_pwm_drive.sv
// motor_pwm_drive: dual-motor direction decode with PWM gating and dead time.
// A command is a 3-bit direction code plus a duty value. A command that
// reverses either motor passes through a dead interval with all drives low.
// Duty changes take effect only at a PWM period boundary.
// Optional feature macro: MOTOR_PWM_RAMP_EN (soft start/stop of the duty value).
//
// state | meaning
// ------+------------------------------------------------------------
// STOP  | pattern is 0000, commands accepted
// RUN   | pattern non-zero, lv gated by PWM, commands accepted
// DEAD  | reversal in progress, lv forced 0000, commands refused

module motor_pwm_drive #(
    parameter int PWM_BITS    = 8,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          direction,
    input  logic [PWM_BITS-1:0] duty,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    output logic [3:0]          lv,
    output logic                dead_active
);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    // last counter value before wrapping; the period is one short of 2^PWM_BITS
    // so an all-ones duty keeps the output permanently on
    localparam logic [PWM_BITS-1:0] CNT_LAST  = {{(PWM_BITS-1){1'b1}}, 1'b0};
    localparam logic [15:0]         DEAD_LOAD = 16'(DEAD_CYCLES - 1);

    state_t              r_state;
    logic [3:0]          r_pattern;
    logic [15:0]         r_dead_cnt;
    logic                r_dead_active;
    logic                r_cmd_ready;
    logic [PWM_BITS-1:0] r_cnt;
    logic [PWM_BITS-1:0] r_duty_q;
    logic [PWM_BITS-1:0] r_duty_tgt;

    logic [3:0]          w_new_pat;
    logic                w_accept;
    logic                w_rev_m1;
    logic                w_rev_m2;
    logic                w_reverse;
    logic                w_enter_dead;
    logic                w_wrap;
    logic [PWM_BITS-1:0] w_target;

    // direction code to drive pattern; no entry sets both bits of a pair
    always_comb begin
        w_new_pat = 4'b0000;
        case (direction)
            3'd1:    w_new_pat = 4'b1010;
            3'd2:    w_new_pat = 4'b1000;
            3'd3:    w_new_pat = 4'b0010;
            3'd4:    w_new_pat = 4'b0101;
            3'd5:    w_new_pat = 4'b1001;
            3'd6:    w_new_pat = 4'b0110;
            default: w_new_pat = 4'b0000;
        endcase
    end

    assign w_accept     = cmd_valid & r_cmd_ready;
    assign w_rev_m1     = (r_pattern[3:2] != 2'b00) && (w_new_pat[3:2] != 2'b00) &&
                          (r_pattern[3:2] != w_new_pat[3:2]);
    assign w_rev_m2     = (r_pattern[1:0] != 2'b00) && (w_new_pat[1:0] != 2'b00) &&
                          (r_pattern[1:0] != w_new_pat[1:0]);
    assign w_reverse    = w_rev_m1 | w_rev_m2;
    assign w_enter_dead = w_accept & w_reverse;
    assign w_wrap       = (r_cnt == CNT_LAST);
    // a command accepted on the wrap cycle already counts for that boundary
    assign w_target     = w_accept ? duty : r_duty_tgt;

    // free-running PWM period counter, also runs in STOP and DEAD
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + PWM_BITS'(1);
        end
    end

    // duty target capture and period-aligned update of the active duty
    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty_tgt <= '0;
            r_duty_q   <= '0;
        end else begin
            if (w_accept) begin
                r_duty_tgt <= duty;
            end
`ifdef MOTOR_PWM_RAMP_EN
            if (w_enter_dead) begin
                r_duty_q <= '0;
            end else if (w_wrap) begin
                if (r_duty_q < w_target) begin
                    r_duty_q <= r_duty_q + PWM_BITS'(1);
                end else if (r_duty_q > w_target) begin
                    r_duty_q <= r_duty_q - PWM_BITS'(1);
                end
            end
`else
            if (w_wrap) begin
                r_duty_q <= w_target;
            end
`endif
        end
    end

    // sequencing FSM with registered handshake and dead-time flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_STOP;
            r_pattern     <= 4'b0000;
            r_dead_cnt    <= '0;
            r_dead_active <= 1'b0;
            r_cmd_ready   <= 1'b1;
        end else begin
            case (r_state)
                ST_STOP, ST_RUN: begin
                    if (w_accept) begin
                        // the new pattern is held through DEAD and released at its end
                        r_pattern <= w_new_pat;
                        if (w_reverse) begin
                            r_state       <= ST_DEAD;
                            r_dead_cnt    <= DEAD_LOAD;
                            r_dead_active <= 1'b1;
                            r_cmd_ready   <= 1'b0;
                        end else if (w_new_pat == 4'b0000) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_DEAD: begin
                    if (r_dead_cnt == 16'd0) begin
                        r_state       <= ST_RUN;
                        r_dead_active <= 1'b0;
                        r_cmd_ready   <= 1'b1;
                    end else begin
                        r_dead_cnt <= r_dead_cnt - 16'd1;
                    end
                end
                default: begin
                    r_state       <= ST_STOP;
                    r_pattern     <= 4'b0000;
                    r_dead_active <= 1'b0;
                    r_cmd_ready   <= 1'b1;
                end
            endcase
        end
    end

    assign lv          = (!r_dead_active && (r_cnt < r_duty_q)) ? r_pattern : 4'b0000;
    assign cmd_ready   = r_cmd_ready;
    assign dead_active = r_dead_active;

endmodule

// File: tb/tb_motor_pwm_drive.sv
// Testbench for motor_pwm_drive (PWM_BITS=4, DEAD_CYCLES=3): constant vector
// table, hand sequences for PWM shape and ramp, then random commands against
// a cycle-count based reference model.
module tb_motor_pwm_drive;
    localparam int PB     = 4;
    localparam int DC     = 3;
    localparam int PERIOD = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    direction;
    logic [PB-1:0] duty;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    lv;
    logic          dead_active;

    int checks = 0;
    int errors = 0;

    int         m_t;
    int         m_duty;
    int         m_tgt;
    int         m_dead;
    logic [3:0] m_pat;
    logic [3:0] pat_tab [8];

    typedef struct {
        bit         r;
        bit         v;
        logic [2:0] d;
        logic [3:0] du;
        logic [3:0] lv;
        bit         dead;
        bit         rdy;
    } vec_t;
    vec_t tab [20];

    motor_pwm_drive #(.PWM_BITS(PB), .DEAD_CYCLES(DC)) dut (
        .clk         (clk),
        .rst         (rst),
        .direction   (direction),
        .duty        (duty),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .lv          (lv),
        .dead_active (dead_active)
    );

    always #5 clk = ~clk;

    function automatic bit is_rev(logic [3:0] a, logic [3:0] b);
        bit r1, r2;
        r1 = (a[3:2] != 0) && (b[3:2] != 0) && (a[3:2] != b[3:2]);
        r2 = (a[1:0] != 0) && (b[1:0] != 0) && (a[1:0] != b[1:0]);
        return r1 || r2;
    endfunction

    task automatic model_step(input bit r, input bit v, input logic [2:0] d, input int du);
        bit acc, wrap, rv;
        if (r) begin
            m_t = 0; m_duty = 0; m_tgt = 0; m_dead = 0; m_pat = 4'b0000;
        end else begin
            acc  = v && (m_dead == 0);
            wrap = (m_t % PERIOD) == PERIOD - 1;
            rv   = 1'b0;
            if (m_dead > 0) m_dead--;
            if (acc) begin
                rv    = is_rev(m_pat, pat_tab[d]);
                m_pat = pat_tab[d];
                m_tgt = du;
                if (rv) m_dead = DC;
            end
`ifdef MOTOR_PWM_RAMP_EN
            if (wrap) begin
                if (m_duty < m_tgt) m_duty++;
                else if (m_duty > m_tgt) m_duty--;
            end
            if (rv) m_duty = 0;
`else
            if (wrap) m_duty = m_tgt;
`endif
            m_t++;
        end
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%b expected=%b", name, $time, act, exp);
        end
    endtask

    task automatic tick(input bit r, input bit v, input logic [2:0] d, input logic [3:0] du);
        logic [3:0] e_lv;
        rst = r; cmd_valid = v; direction = d; duty = du;
        @(posedge clk);
        model_step(r, v, d, int'(du));
        #1;
        e_lv = ((m_dead > 0) || ((m_t % PERIOD) >= m_duty)) ? 4'b0000 : m_pat;
        check("model_lv", lv, e_lv);
        check("model_dead", {3'b0, dead_active}, {3'b0, m_dead > 0});
        check("model_ready", {3'b0, cmd_ready}, {3'b0, m_dead == 0});
        check("pair_exclusive", {2'b0, lv[3] & lv[2], lv[1] & lv[0]}, 4'b0000);
    endtask

    task automatic align();
        for (int i = 0; i < PERIOD + 1; i++) begin
            if (m_t % PERIOD == 0) break;
            tick(0, 0, 3'd0, 4'd0);
        end
    endtask

    initial begin
        int on_cnt;
        int ramp_exp [4];
        pat_tab = '{4'b0000, 4'b1010, 4'b1000, 4'b0010, 4'b0101, 4'b1001, 4'b0110, 4'b0000};
        //          r  v  d     du     lv       dead rdy
        tab[0]  = '{0, 1, 3'd2, 4'd15, 4'b1000, 0, 1};
        tab[1]  = '{0, 1, 3'd3, 4'd15, 4'b0010, 0, 1};
        tab[2]  = '{0, 1, 3'd6, 4'd15, 4'b0110, 0, 1};
        tab[3]  = '{0, 1, 3'd5, 4'd15, 4'b0000, 1, 0};
        tab[4]  = '{0, 0, 3'd0, 4'd15, 4'b0000, 1, 0};
        tab[5]  = '{0, 0, 3'd0, 4'd15, 4'b0000, 1, 0};
        tab[6]  = '{0, 0, 3'd0, 4'd15, 4'b1001, 0, 1};
        tab[7]  = '{0, 1, 3'd7, 4'd15, 4'b0000, 0, 1};
        tab[8]  = '{0, 1, 3'd4, 4'd15, 4'b0101, 0, 1};
        tab[9]  = '{0, 1, 3'd0, 4'd15, 4'b0000, 0, 1};
        tab[10] = '{0, 1, 3'd1, 4'd15, 4'b1010, 0, 1};
        tab[11] = '{0, 1, 3'd4, 4'd15, 4'b0000, 1, 0};
        tab[12] = '{0, 1, 3'd0, 4'd15, 4'b0000, 1, 0};
        tab[13] = '{0, 0, 3'd0, 4'd15, 4'b0000, 1, 0};
        tab[14] = '{0, 0, 3'd0, 4'd15, 4'b0101, 0, 1};
        tab[15] = '{0, 1, 3'd1, 4'd15, 4'b0000, 1, 0};
        tab[16] = '{1, 0, 3'd0, 4'd15, 4'b0000, 0, 1};
        tab[17] = '{1, 1, 3'd1, 4'd15, 4'b0000, 0, 1};
        tab[18] = '{0, 0, 3'd0, 4'd15, 4'b0000, 0, 1};
        tab[19] = '{0, 1, 3'd4, 4'd15, 4'b0000, 0, 1};
        ramp_exp = '{1, 2, 3, 3};

        rst = 1'b1; cmd_valid = 1'b0; direction = 3'd0; duty = '0;
        m_t = 0; m_duty = 0; m_tgt = 0; m_dead = 0; m_pat = 4'b0000;

        // reset held two cycles, then released
        tick(1, 0, 3'd0, 4'd0);
        tick(1, 0, 3'd0, 4'd0);
        check("reset_lv", lv, 4'b0000);
        check("reset_ready", {3'b0, cmd_ready}, 4'd1);
        check("reset_dead", {3'b0, dead_active}, 4'd0);
        tick(0, 0, 3'd0, 4'd0);
        check("post_reset_lv", lv, 4'b0000);
        check("post_reset_ready", {3'b0, cmd_ready}, 4'd1);

`ifndef MOTOR_PWM_RAMP_EN
        // full duty forward, wait for the period boundary, then the vector table
        tick(0, 1, 3'd1, 4'd15);
        align();
        check("full_duty_lv", lv, 4'b1010);
        for (int i = 0; i < 20; i++) begin
            tick(tab[i].r, tab[i].v, tab[i].d, tab[i].du);
            check($sformatf("tab%0d_lv", i), lv, tab[i].lv);
            check($sformatf("tab%0d_dead", i), {3'b0, dead_active}, {3'b0, tab[i].dead});
            check($sformatf("tab%0d_ready", i), {3'b0, cmd_ready}, {3'b0, tab[i].rdy});
        end

        // duty 5 forward: 5 on, 10 off, every 15 cycles
        tick(1, 0, 3'd0, 4'd0);
        tick(0, 1, 3'd1, 4'd5);
        align();
        for (int i = 0; i < 2 * PERIOD; i++) begin
            check("pwm5_lv", lv, ((i % PERIOD) < 5) ? 4'b1010 : 4'b0000);
            tick(0, 0, 3'd0, 4'd0);
        end

        // duty 0: output stays low for a whole period
        tick(0, 1, 3'd1, 4'd0);
        align();
        for (int i = 0; i < PERIOD; i++) begin
            check("pwm0_lv", lv, 4'b0000);
            tick(0, 0, 3'd0, 4'd0);
        end
`else
        // soft start: on-time grows by one per period up to the target
        tick(0, 1, 3'd1, 4'd3);
        align();
        for (int p = 0; p < 4; p++) begin
            on_cnt = 0;
            for (int i = 0; i < PERIOD; i++) begin
                if (lv != 4'b0000) on_cnt++;
                tick(0, 0, 3'd0, 4'd0);
            end
            check($sformatf("ramp_period%0d", p), 4'(on_cnt), 4'(ramp_exp[p]));
        end
`endif

        // random commands against the reference model
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] du;
            du = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 4'd15 : 4'd0)
                                            : 4'($urandom_range(0, 15));
            tick($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 2,
                 3'($urandom_range(0, 7)), du);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
